// File: rtl/hazard_pkg.sv
// Shared types and defaults for the operand hazard scoreboard and its forwarding selectors.
package hazard_pkg;

   localparam int unsigned ZERO_REG_DEF = 31;
   localparam int unsigned LOAD_LAT_DEF = 1;
   localparam int unsigned REG_AW_MAX   = 8;

   // rd is held at the widest supported address width; narrower addresses are zero-extended
   typedef struct packed {
      logic                  valid;
      logic [REG_AW_MAX-1:0] rd;
      logic                  we;
      logic                  ld;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: {REG_AW_MAX{1'b0}}, we: 1'b0, ld: 1'b0};

endpackage

// File: rtl/fwd_select.sv
// Per-operand youngest-match search over the scoreboard, load-readiness check and operand mux.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
   parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
   input  logic [DEPTH-1:0]            ent_valid,
   input  logic [DEPTH-1:0]            ent_we,
   input  logic [DEPTH-1:0]            ent_ld,
   input  logic [DEPTH*REG_AW_MAX-1:0] ent_rd,
   input  logic [REG_AW-1:0]           rs,
   input  logic [DATA_W-1:0]           rf,
   input  logic [DEPTH*DATA_W-1:0]     stage_data,
   output logic [DATA_W-1:0]           fwd,
   output logic                        not_ready
);

   localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

   logic [REG_AW_MAX-1:0] rs_ext_s;
   logic                  is_zero_s;
   logic                  hit_s;
   logic                  early_s;
   logic [DATA_W-1:0]     hit_data_s;

   // zero-extend the source address to the stored rd width
   always_comb begin
      rs_ext_s             = {REG_AW_MAX{1'b0}};
      rs_ext_s[REG_AW-1:0] = rs;
   end

   assign is_zero_s = (rs == ZERO_IDX);

   // walk oldest to youngest so the lowest matching index wins
   always_comb begin
      hit_s      = 1'b0;
      early_s    = 1'b0;
      hit_data_s = {DATA_W{1'b0}};
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (ent_valid[k] && ent_we[k] && !is_zero_s &&
             (ent_rd[k*REG_AW_MAX +: REG_AW_MAX] == rs_ext_s)) begin
            hit_s      = 1'b1;
            hit_data_s = stage_data[k*DATA_W +: DATA_W];
            early_s    = ent_ld[k] && (k < int'(LOAD_LAT));
         end else begin
            hit_s      = hit_s;
         end
      end
   end

   // operand mux: hard zero, youngest in-flight result, or register file
   always_comb begin
      if (is_zero_s) begin
         fwd = {DATA_W{1'b0}};
      end else if (hit_s) begin
         fwd = hit_data_s;
      end else begin
         fwd = rf;
      end
   end

   assign not_ready = hit_s && early_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard driving operand forwarding, load-use stall and a stall counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
   parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    issue_valid,
   input  logic [REG_AW-1:0]       issue_rd,
   input  logic                    issue_we,
   input  logic                    issue_ld,
   input  logic [REG_AW-1:0]       rs_a,
   input  logic [REG_AW-1:0]       rs_b,
   input  logic [DATA_W-1:0]       rf_a,
   input  logic [DATA_W-1:0]       rf_b,
   input  logic [DEPTH*DATA_W-1:0] stage_data,
   input  logic                    flush,
   input  logic [DEPTH-1:0]        flush_mask,
   output logic [DATA_W-1:0]       fwd_a,
   output logic [DATA_W-1:0]       fwd_b,
   output logic                    stall,
   output logic [31:0]             stall_cnt
);

   sb_entry_t                   sb_r [DEPTH];
   sb_entry_t                   issue_entry_s;
   logic [DEPTH-1:0]            ent_valid_s;
   logic [DEPTH-1:0]            ent_we_s;
   logic [DEPTH-1:0]            ent_ld_s;
   logic [DEPTH*REG_AW_MAX-1:0] ent_rd_s;
   logic                        nr_a_s;
   logic                        nr_b_s;
   logic                        stall_s;
   logic [31:0]                 stall_cnt_r;
   logic                        unused_flush_s;

   // the last stage retires unconditionally, so its kill bit has nothing to act on
   assign unused_flush_s = flush_mask[DEPTH-1];

   // build the entry that would enter stage 0
   always_comb begin
      issue_entry_s                = SB_BUBBLE;
      issue_entry_s.valid          = 1'b1;
      issue_entry_s.we             = issue_we;
      issue_entry_s.ld             = issue_ld;
      issue_entry_s.rd[REG_AW-1:0] = issue_rd;
   end

   // flatten scoreboard state for the per-operand selectors
   always_comb begin
      ent_valid_s = {DEPTH{1'b0}};
      ent_we_s    = {DEPTH{1'b0}};
      ent_ld_s    = {DEPTH{1'b0}};
      ent_rd_s    = {(DEPTH*REG_AW_MAX){1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         ent_valid_s[k]                         = sb_r[k].valid;
         ent_we_s[k]                            = sb_r[k].we;
         ent_ld_s[k]                            = sb_r[k].ld;
         ent_rd_s[k*REG_AW_MAX +: REG_AW_MAX]   = sb_r[k].rd;
      end
   end

   fwd_select #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
      .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG)
   ) u_fwd_a (
      .ent_valid(ent_valid_s), .ent_we(ent_we_s), .ent_ld(ent_ld_s), .ent_rd(ent_rd_s),
      .rs(rs_a), .rf(rf_a), .stage_data(stage_data),
      .fwd(fwd_a), .not_ready(nr_a_s)
   );

   fwd_select #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH),
      .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG)
   ) u_fwd_b (
      .ent_valid(ent_valid_s), .ent_we(ent_we_s), .ent_ld(ent_ld_s), .ent_rd(ent_rd_s),
      .rs(rs_b), .rf(rf_b), .stage_data(stage_data),
      .fwd(fwd_b), .not_ready(nr_b_s)
   );

   assign stall_s   = issue_valid && (nr_a_s || nr_b_s);
   assign stall     = stall_s;
   assign stall_cnt = stall_cnt_r;

   // scoreboard shift: issue or bubble into stage 0, per-stage kill on the way down
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            sb_r[k] <= SB_BUBBLE;
         end
      end else begin
         if (issue_valid && !stall_s && !flush) begin
            sb_r[0] <= issue_entry_s;
         end else begin
            sb_r[0] <= SB_BUBBLE;
         end
         for (int k = 0; k < DEPTH - 1; k++) begin
            if (flush_mask[k]) begin
               sb_r[k+1] <= SB_BUBBLE;
            end else begin
               sb_r[k+1] <= sb_r[k];
            end
         end
      end
   end

   // saturating stall counter; flushed cycles are not counted
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= 32'h0000_0000;
      end else if (stall_s && !flush && (stall_cnt_r != 32'hFFFF_FFFF)) begin
         stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters (DEPTH=2, LOAD_LAT=1, ZERO_REG=31).
module tb_hazard_scoreboard;

   logic         clk = 1'b0;
   logic         reset;
   logic         issue_valid;
   logic [4:0]   issue_rd;
   logic         issue_we;
   logic         issue_ld;
   logic [4:0]   rs_a;
   logic [4:0]   rs_b;
   logic [63:0]  rf_a;
   logic [63:0]  rf_b;
   logic [127:0] stage_data;
   logic         flush;
   logic [1:0]   flush_mask;
   logic [63:0]  fwd_a;
   logic [63:0]  fwd_b;
   logic         stall;
   logic [31:0]  stall_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we), .issue_ld(issue_ld),
      .rs_a(rs_a), .rs_b(rs_b), .rf_a(rf_a), .rf_b(rf_b),
      .stage_data(stage_data), .flush(flush), .flush_mask(flush_mask),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance one edge; inputs are changed 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_rd = 5'd0; issue_we = 1'b0; issue_ld = 1'b0;
      rs_a = 5'd0; rs_b = 5'd0; flush = 1'b0; flush_mask = 2'b00;
   endtask

   task automatic issue(input logic [4:0] rd, input logic we, input logic ld);
      issue_valid = 1'b1; issue_rd = rd; issue_we = we; issue_ld = ld;
   endtask

   initial begin
      reset = 1'b1;
      rf_a = 64'h111; rf_b = 64'h222;
      stage_data = {64'hDEAD_0001, 64'hDEAD_0000};
      idle();
      tick(); tick();
      reset = 1'b0;
      rs_a = 5'd1; rs_b = 5'd31;
      #2;
      check_eq("rst_stall", {63'd0, stall}, 64'd0);
      check_eq("rst_cnt", {32'd0, stall_cnt}, 64'd0);
      check_eq("rst_fwd_a", fwd_a, 64'h111);
      check_eq("rst_fwd_b_zero", fwd_b, 64'd0);

      // ADD X1 then SUB reads X1 from EX
      tick(); idle(); issue(5'd1, 1'b1, 1'b0);
      tick(); issue(5'd4, 1'b1, 1'b0); rs_a = 5'd1; rf_a = 64'h99;
      stage_data = {64'h7, 64'h5};
      #2;
      check_eq("add_sub_fwd_a", fwd_a, 64'h5);
      check_eq("add_sub_stall", {63'd0, stall}, 64'd0);
      tick(); idle(); rs_a = 5'd1;
      #2;
      check_eq("fwd_stage1", fwd_a, 64'h7);
      tick(); tick();

      // load-use: one stall cycle then forward from stage 1
      issue(5'd2, 1'b1, 1'b1);
      tick(); issue(5'd5, 1'b1, 1'b0); rs_b = 5'd2;
      stage_data = {64'h77, 64'h66};
      #2;
      check_eq("lu_stall", {63'd0, stall}, 64'd1);
      tick();
      #2;
      check_eq("lu_stall_cnt", {32'd0, stall_cnt}, 64'd1);
      check_eq("lu_stall_clear", {63'd0, stall}, 64'd0);
      check_eq("lu_fwd_b", fwd_b, 64'h77);
      tick(); idle(); tick(); tick();

      // two writers to X3: youngest wins
      issue(5'd3, 1'b1, 1'b0);
      tick(); issue(5'd3, 1'b1, 1'b0);
      tick(); idle(); rs_a = 5'd3; stage_data = {64'hB, 64'hA};
      #2;
      check_eq("youngest_fwd_a", fwd_a, 64'hA);
      tick(); tick();

      // load to X31 never forwards nor stalls
      issue(5'd31, 1'b1, 1'b1);
      tick(); issue(5'd10, 1'b1, 1'b0); rs_a = 5'd31; rf_a = 64'hFF;
      #2;
      check_eq("x31_fwd_a", fwd_a, 64'd0);
      check_eq("x31_stall", {63'd0, stall}, 64'd0);
      tick(); idle(); tick(); tick();

      // load-use stall coinciding with flush
      issue(5'd6, 1'b1, 1'b1);
      tick(); issue(5'd7, 1'b1, 1'b0); rs_a = 5'd6; flush = 1'b1;
      #2;
      check_eq("flush_stall", {63'd0, stall}, 64'd1);
      tick(); idle(); rs_a = 5'd6; rs_b = 5'd7; rf_b = 64'h333;
      stage_data = {64'h61, 64'h60};
      #2;
      check_eq("flush_cnt_hold", {32'd0, stall_cnt}, 64'd1);
      check_eq("flush_ld_stage1", fwd_a, 64'h61);
      check_eq("flush_bubble", fwd_b, 64'h333);
      tick(); tick();

      // flush_mask[0] kills stage-0 writer before it reaches stage 1
      issue(5'd8, 1'b1, 1'b0);
      tick(); idle(); rs_a = 5'd8; rf_a = 64'h88; flush_mask = 2'b01;
      #2;
      check_eq("mask_pre_fwd", fwd_a, 64'h60);
      tick(); flush_mask = 2'b00;
      #2;
      check_eq("mask_killed_rf", fwd_a, 64'h88);
      tick(); tick();

      // reset during load-use stall
      issue(5'd9, 1'b1, 1'b1);
      tick(); issue(5'd11, 1'b1, 1'b0); rs_a = 5'd9; rf_a = 64'h909;
      #2;
      check_eq("rst_mid_stall", {63'd0, stall}, 64'd1);
      reset = 1'b1;
      tick(); reset = 1'b0;
      #2;
      check_eq("rst_after_stall", {63'd0, stall}, 64'd0);
      check_eq("rst_after_cnt", {32'd0, stall_cnt}, 64'd0);
      check_eq("rst_after_fwd", fwd_a, 64'h909);
      tick(); idle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
